// File: rtl/pipe_stage_reg.sv
// Elastic multi-stage pipeline register with a valid/ready handshake on both sides.
// The register supports a synchronous flush, bubble collapse and an optional input skid entry that keeps in_ready registered.
module pipe_stage_reg #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int SKID  = 1,
    parameter int CNTW  = $clog2(DEPTH + SKID + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNTW-1:0]  count
);

    logic [DEPTH-1:0] r_valid;
    logic [WIDTH-1:0] r_data [DEPTH];
    logic [CNTW-1:0]  r_count;

    logic [DEPTH-1:0] w_acc;
    logic [DEPTH-1:0] w_adv;
    logic [DEPTH-1:0] w_load;
    logic [DEPTH-1:0] w_validNext;
    logic             w_srcValid;
    logic [WIDTH-1:0] w_srcData;
    logic             w_skidNext;
    logic [CNTW-1:0]  w_countNext;

    // Walk from the tail towards the input so that each stage sees whether the stage after it can take data.
    always_comb begin
        logic carry;
        w_acc = '0;
        w_adv = '0;
        carry = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_adv[i] = carry;
            w_acc[i] = !r_valid[i] || carry;
            carry    = w_acc[i];
        end
    end

    always_comb begin
        w_load      = '0;
        w_validNext = r_valid;
        w_load[0]   = w_acc[0] && w_srcValid;
        for (int i = 1; i < DEPTH; i++) begin
            w_load[i] = w_acc[i] && r_valid[i-1];
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (flush) begin
                w_validNext[i] = 1'b0;
            end else if (w_load[i]) begin
                w_validNext[i] = 1'b1;
            end else if (w_adv[i]) begin
                w_validNext[i] = 1'b0;
            end
        end
    end

    if (SKID != 0) begin : g_skid
        logic             r_skidValid;
        logic [WIDTH-1:0] r_skidData;

        // The skid entry catches a payload that is accepted while stage 0 is blocked. It always drains ahead of newer input.
        assign w_skidNext = !flush && (r_skidValid ? !w_acc[0] : (in_valid && !w_acc[0]));
        assign in_ready   = !r_skidValid;
        assign w_srcValid = r_skidValid || in_valid;
        assign w_srcData  = r_skidValid ? r_skidData : in_data;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_skidValid <= 1'b0;
                r_skidData  <= '0;
            end else begin
                r_skidValid <= w_skidNext;
                if (!flush && !r_skidValid && in_valid && !w_acc[0]) begin
                    r_skidData <= in_data;
                end
            end
        end
    end else begin : g_noSkid
        assign w_skidNext = 1'b0;
        assign in_ready   = w_acc[0];
        assign w_srcValid = in_valid;
        assign w_srcData  = in_data;
    end

    always_comb begin
        w_countNext = CNTW'(w_skidNext);
        for (int i = 0; i < DEPTH; i++) begin
            w_countNext = w_countNext + CNTW'(w_validNext[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_count <= '0;
        end else begin
            r_valid <= w_validNext;
            r_count <= w_countNext;
        end
    end

    // Data registers load only on an actual transfer into the stage, so invalid stages keep their stale contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
        end else if (!flush) begin
            if (w_load[0]) begin
                r_data[0] <= w_srcData;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (w_load[i]) begin
                    r_data[i] <= r_data[i-1];
                end
            end
        end
    end

    assign out_valid = r_valid[DEPTH-1];
    assign out_data  = r_data[DEPTH-1];
    assign count     = r_count;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg.
// It checks a DEPTH=3 SKID=1 instance and a DEPTH=1 SKID=0 instance.
module tb_pipe_stage_reg;

    logic        clk;
    logic        rst;

    logic        aFlush, aInValid, aInReady, aOutValid, aOutReady;
    logic [31:0] aInData, aOutData;
    logic [2:0]  aCount;

    logic        bFlush, bInValid, bInReady, bOutValid, bOutReady;
    logic [31:0] bInData, bOutData;
    logic [0:0]  bCount;

    int tests;
    int failed;
    int transfers;

    pipe_stage_reg #(.WIDTH(32), .DEPTH(3), .SKID(1)) dutA (
        .clk(clk), .rst(rst), .flush(aFlush),
        .in_valid(aInValid), .in_ready(aInReady), .in_data(aInData),
        .out_valid(aOutValid), .out_ready(aOutReady), .out_data(aOutData),
        .count(aCount)
    );

    pipe_stage_reg #(.WIDTH(32), .DEPTH(1), .SKID(0)) dutB (
        .clk(clk), .rst(rst), .flush(bFlush),
        .in_valid(bInValid), .in_ready(bInReady), .in_data(bInData),
        .out_valid(bOutValid), .out_ready(bOutReady), .out_data(bOutData),
        .count(bCount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] data, input logic ordy, input logic fl);
        aInValid  = valid;
        aInData   = data;
        aOutReady = ordy;
        aFlush    = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        failed = 0;
        transfers = 0;
        rst = 1'b1;
        aFlush = 1'b0; aInValid = 1'b0; aInData = '0; aOutReady = 1'b0;
        bFlush = 1'b0; bInValid = 1'b0; bInData = '0; bOutReady = 1'b0;

        #1;
        checkOutput("rst_outValid", 64'(aOutValid), 64'd0);
        checkOutput("rst_outData", 64'(aOutData), 64'd0);
        checkOutput("rst_count", 64'(aCount), 64'd0);
        checkOutput("rst_inReady", 64'(aInReady), 64'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rel_inReady", 64'(aInReady), 64'd1);

        // Streaming 1..10 with out_ready held high
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, 32'(k + 1), 1'b1, 1'b0);
            if (k < 2) begin
                checkOutput("stream_noOut", 64'(aOutValid), 64'd0);
            end else begin
                checkOutput("stream_outValid", 64'(aOutValid), 64'd1);
                checkOutput("stream_outData", 64'(aOutData), 64'(k - 1));
                checkOutput("stream_count", 64'(aCount), 64'd3);
            end
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("drain_data9", 64'(aOutData), 64'h9);
        checkOutput("drain_count2", 64'(aCount), 64'd2);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("drain_dataA", 64'(aOutData), 64'hA);
        checkOutput("drain_count1", 64'(aCount), 64'd1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("drain_empty", 64'(aOutValid), 64'd0);
        checkOutput("drain_count0", 64'(aCount), 64'd0);

        // Backpressure fill into the skid entry
        applyStimulus(1'b1, 32'hA0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hA1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hA2, 1'b0, 1'b0);
        checkOutput("bp_count3", 64'(aCount), 64'd3);
        checkOutput("bp_inReady3", 64'(aInReady), 64'd1);
        applyStimulus(1'b1, 32'hA3, 1'b0, 1'b0);
        checkOutput("bp_count4", 64'(aCount), 64'd4);
        checkOutput("bp_inReady4", 64'(aInReady), 64'd0);
        checkOutput("bp_head", 64'(aOutData), 64'hA0);
        applyStimulus(1'b1, 32'hBB, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("bp_stallData", 64'(aOutData), 64'hA0);
        checkOutput("bp_stallValid", 64'(aOutValid), 64'd1);
        checkOutput("bp_stallCount", 64'(aCount), 64'd4);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("bp_out1", 64'(aOutData), 64'hA1);
        checkOutput("bp_cnt3", 64'(aCount), 64'd3);
        checkOutput("bp_inReadyBack", 64'(aInReady), 64'd1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("bp_out2", 64'(aOutData), 64'hA2);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("bp_out3", 64'(aOutData), 64'hA3);
        checkOutput("bp_cnt1", 64'(aCount), 64'd1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("bp_empty", 64'(aOutValid), 64'd0);

        // Bubble collapse behind a stalled tail
        applyStimulus(1'b1, 32'h11, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h22, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("bub_head", 64'(aOutData), 64'h11);
        checkOutput("bub_count", 64'(aCount), 64'd2);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("bub_second", 64'(aOutData), 64'h22);
        checkOutput("bub_count1", 64'(aCount), 64'd1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("bub_empty", 64'(aCount), 64'd0);

        // Flush with the pipe full and an input pending
        applyStimulus(1'b1, 32'h5, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h6, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h7, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h8, 1'b0, 1'b0);
        checkOutput("fl_full", 64'(aCount), 64'd4);
        applyStimulus(1'b1, 32'h9, 1'b0, 1'b1);
        checkOutput("fl_outValid", 64'(aOutValid), 64'd0);
        checkOutput("fl_count", 64'(aCount), 64'd0);
        checkOutput("fl_inReady", 64'(aInReady), 64'd1);
        applyStimulus(1'b1, 32'h9, 1'b1, 1'b1);
        checkOutput("fl_dropCount", 64'(aCount), 64'd0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
            checkOutput("fl_noEmit", 64'(aOutValid), 64'd0);
        end

        // Asynchronous reset between clock edges
        applyStimulus(1'b1, 32'h1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h2, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h3, 1'b0, 1'b0);
        aInValid = 1'b0;
        checkOutput("ar_pre", 64'(aCount), 64'd3);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("ar_outValid", 64'(aOutValid), 64'd0);
        checkOutput("ar_outData", 64'(aOutData), 64'd0);
        checkOutput("ar_count", 64'(aCount), 64'd0);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
            checkOutput("ar_noOut", 64'(aOutValid), 64'd0);
        end

        // SKID=0, DEPTH=1 with out_ready toggling
        bInValid  = 1'b1;
        bInData   = 32'hFFFF_FFFF;
        bOutReady = 1'b0;
        #1;
        checkOutput("b_emptyReady", 64'(bInReady), 64'd1);
        @(posedge clk);
        #1;
        checkOutput("b_loaded", 64'(bCount), 64'd1);
        for (int k = 0; k < 8; k++) begin
            bOutReady = (k % 2 == 1);
            #1;
            checkOutput("b_combReady", 64'(bInReady), 64'(k % 2));
            if (bOutValid && bOutReady) begin
                transfers++;
            end
            @(posedge clk);
            #1;
            checkOutput("b_count", 64'(bCount), 64'd1);
            checkOutput("b_data", 64'(bOutData), 64'hFFFF_FFFF);
        end
        checkOutput("b_transfers", 64'(transfers), 64'd4);
        bInValid  = 1'b0;
        bOutReady = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("b_drained", 64'(bOutValid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
